// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
//   Load/store initiator between the core MEM stage and a word-wide,
//   handshaked data memory port. Accepts one request at a time, issues one
//   or two aligned word accesses (misaligned half/word accesses are split),
//   and returns extended load data with a single-cycle response pulse. A
//   watchdog aborts an access that waits TIMEOUT cycles without an ack.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid           request present
//   o_req_ready           high only while idle
//   i_req_we              1 = store, 0 = load
//   i_req_addr[31:0]      byte address
//   i_req_rw_type[2:0]    [1:0] 00 byte/01 half/10 word/11 illegal,
//                         [2] zero-extend load
//   i_req_wdata[31:0]     right-justified store data
//   o_rsp_valid           one-cycle completion pulse
//   o_rsp_rdata[31:0]     extended load data (0 for stores/errors)
//   o_rsp_err             illegal type or timeout, qualified by o_rsp_valid
//   o_mem_req/o_mem_we    memory access request / write
//   o_mem_addr[31:0]      word-aligned address
//   o_mem_be[3:0]         byte-lane write enables (0 for reads)
//   o_mem_wdata[31:0]     lane-aligned write data
//   i_mem_ack             access complete, read data valid same cycle
//   i_mem_rdata[31:0]     read word
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_rw_type,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [2:0]    r_type;
    logic [31:0]   r_wdata;
    logic [31:0]   r_lo;
    // Only the low three bytes of the second word can ever reach the result.
    logic [23:0]   r_hi;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_off;
    logic          w_split;
    logic [3:0]    w_mask;
    logic [7:0]    w_be8;
    logic [63:0]   w_wd64;
    logic [31:0]   w_base;
    logic [31:0]   w_rdv;
    logic [31:0]   w_ext;

    assign w_off   = r_addr[1:0];
    assign w_split = ((r_type[1:0] == 2'b01) && (w_off == 2'b11)) ||
                     ((r_type[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_base  = {r_addr[31:2], 2'b00};
    assign w_be8   = {4'b0000, w_mask} << w_off;
    assign w_wd64  = {32'b0, r_wdata} << {w_off, 3'b000};

    always_comb begin
        w_mask = 4'b0000;
        case (r_type[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            2'b10:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    // ({hi, lo} >> 8*off)[31:0], written per offset
    always_comb begin
        w_rdv = r_lo;
        case (w_off)
            2'd0:    w_rdv = r_lo;
            2'd1:    w_rdv = {r_hi[7:0],  r_lo[31:8]};
            2'd2:    w_rdv = {r_hi[15:0], r_lo[31:16]};
            default: w_rdv = {r_hi[23:0], r_lo[31:24]};
        endcase
    end

    always_comb begin
        w_ext = w_rdv;
        case (r_type[1:0])
            2'b00:   w_ext = r_type[2] ? {24'b0, w_rdv[7:0]}
                                       : {{24{w_rdv[7]}}, w_rdv[7:0]};
            2'b01:   w_ext = r_type[2] ? {16'b0, w_rdv[15:0]}
                                       : {{16{w_rdv[15]}}, w_rdv[15:0]};
            default: w_ext = w_rdv;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_type  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_addr  <= i_req_addr;
                        r_type  <= i_req_rw_type;
                        r_wdata <= i_req_wdata;
                        r_lo    <= '0;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        if (i_req_rw_type[1:0] == 2'b11) begin
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    if (i_mem_ack) begin
                        if (!r_we) r_lo <= i_mem_rdata;
                        r_cnt   <= '0;
                        r_state <= w_split ? S_ACC1 : S_RESP;
                    end else if (r_cnt == LP_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACC1: begin
                    if (i_mem_ack) begin
                        if (!r_we) r_hi <= i_mem_rdata[23:0];
                        r_state <= S_RESP;
                    end else if (r_cnt == LP_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs decode from state and request registers, which are
    // frozen outside IDLE, so they hold steady across wait states and drop as
    // soon as reset forces the state back to IDLE.
    always_comb begin
        o_req_ready = (r_state == S_IDLE);
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_be    = '0;
        o_mem_wdata = '0;
        case (r_state)
            S_ACC0: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = w_base;
                o_mem_be    = r_we ? w_be8[3:0] : 4'b0000;
                o_mem_wdata = w_wd64[31:0];
            end
            S_ACC1: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = w_base + 32'd4;
                o_mem_be    = r_we ? w_be8[7:4] : 4'b0000;
                o_mem_wdata = w_wd64[63:32];
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_err;
                o_rsp_rdata = (r_err || r_we) ? 32'b0 : w_ext;
            end
            default: ;
        endcase
    end

endmodule
